multi_reg_sequencer: RTL and testbench
======================================

# multi_reg_sequencer

Multi-register transfer sequencer for the processor datapath. It drives the register bank's read port (A1/RD1) and write port (A3/WE3/WD3) from the other side of that interface. It moves a 16-bit register list to or from data memory one word at a time, for LDM/STM-style block transfers. The controller starts it with a single `start` pulse, and it reports completion with a one-cycle `done` pulse.

## Interface
- `NREG`, 16: number of architectural registers; the list is NREG bits wide and addresses are $clog2(NREG) bits.
- `DATA_W`, 32: register and memory data width.
- `ADDR_W`, 32: memory byte-address width.

- `clk`  in  1  single clock, all state on posedge.
- `rst`  in  1  reset, asynchronous, active-low; all state is cleared while `rst`=0.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `is_load`  in  1  1 = memory→registers (LDM), 0 = registers→memory (STM); latched at start.
- `reg_list`  in  NREG  register mask, latched at start.
- `base_addr`  in  ADDR_W  first transfer address, latched at start.
- `A1`  out  4  register bank read address.
- `RD1`  in  DATA_W  register bank read data; valid one posedge after A1 is presented.
- `A3`  out  4  register bank write address.
- `WE3`  out  1  register bank write enable.
- `WD3`  out  DATA_W  register bank write data.
- `mem_req`, `mem_we`  out  1  memory request and write qualifier.
- `mem_addr`  out  ADDR_W  memory byte address.
- `mem_wdata`  out  DATA_W  memory store data.
- `mem_ack`  in  1  memory completion; one-cycle pulse.
- `mem_rdata`  in  DATA_W  load data; valid in the `mem_ack` cycle.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `final_addr`  out  ADDR_W  base_addr + 4·popcount(reg_list); valid from `done` onward and held until the next start.

## Operation
- **Reset values.** All outputs reset to 0. State resets to IDLE and the latched list/address reset to 0.
- **Transfer order.** Registers transfer in ascending index order, lowest set bit first. Addressing is increment-after: address = base + 4·k for the k-th transferred register.
- **States and transitions.**
  - IDLE → (start) → SEL.
  - SEL: if the pending mask is 0, go to DONE. Otherwise pick the lowest set index i and clear bit i. If the transfer is a store, go to RDREG; if a load, go to MEMRD.
  - RDREG: A1=i for one cycle → STWAIT.
  - STWAIT: capture RD1 into mem_wdata and assert mem_req=1, mem_we=1 → MEMWR.
  - MEMWR: hold req/addr/wdata until mem_ack, then addr += 4 → SEL.
  - MEMRD: mem_req=1, mem_we=0; hold until mem_ack, then capture mem_rdata into WD3 and set A3=i → REGWR.
  - REGWR: WE3=1 for exactly one cycle, addr += 4 → SEL.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- **Bus quiet rules.** WE3 is never high outside REGWR. mem_req is never high outside MEMWR/MEMRD.
- **Busy start.** `start` while not in IDLE is ignored, and the latched inputs do not change.
- **Empty list.** An empty reg_list produces no memory or register access. `done` pulses 2 cycles after the start cycle, and final_addr = base_addr.
- **Index 15.** Index 15 is transferred like any other register.
- **Address wrap.** The address wraps modulo 2^ADDR_W with no error.
- **mem_ack outside a request state** is ignored.
- **Reset mid-operation.** Outputs go to 0 immediately. No done pulse is issued and no further bank write occurs.

## Timing
- **Store.** 3 cycles + memory wait per register: RDREG, STWAIT, then ≥1 MEMWR cycle.
- **Load.** ≥1 MEMRD cycle + 1 REGWR cycle per register.
- **Overhead.** One SEL cycle per register, plus one final SEL cycle and one DONE cycle.
- **Zero-wait memory.** With mem_ack in the first request cycle, an n-register STM takes 4n+2 cycles from the start cycle to done, and an LDM takes 3n+2.
- **Registered outputs.** All outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mrs_pkg`:
  - state enum `mrs_state_t` (IDLE, SEL, RDREG, STWAIT, MEMWR, MEMRD, REGWR, DONE);
  - `WORD_BYTES = 4`;
  - reset values.
- Sub-module `lowest_set16`: combinational priority encoder over NREG bits, output `{valid, index}`.

## Test plan
- **STM.** R0=0xA, R2=0xB; STM reg_list=0x0005, base=0x100, ack in the same cycle → memory writes 0xA@0x100 then 0xB@0x104; done at cycle 10; final_addr=0x108.
- **LDM.** reg_list=0x8001, base=0x200; memory returns 0x11 then 0x22 → WE3 pulses with A3=0/WD3=0x11 and A3=15/WD3=0x22; final_addr=0x208.
- **Empty list.** reg_list=0, base=0x40 → no mem_req, no WE3; done 2 cycles after start; final_addr=0x40.
- **Ack delays.** mem_ack delayed 3 cycles on each access → mem_req/mem_addr held stable throughout; data order is correct.
- **Start while busy.** Second start during busy with a different list → ignored; only the first transfer completes.
- **Reset mid-transfer.** rst low in the middle of a 4-register LDM → all outputs 0 asynchronously, no done. A start after release works normally.

Source files
------------

// File: rtl/mrs_pkg.sv
// Shared types and constants for the multi-register transfer sequencer.
// The block copies a register list to or from data memory (LDM/STM).
package mrs_pkg;

    localparam int unsigned MRS_NREG   = 16;
    localparam int unsigned MRS_DATA_W = 32;
    localparam int unsigned MRS_ADDR_W = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEL    = 3'd1,
        RDREG  = 3'd2,
        STWAIT = 3'd3,
        MEMWR  = 3'd4,
        MEMRD  = 3'd5,
        REGWR  = 3'd6,
        DONE   = 3'd7
    } mrs_state_t;

    localparam mrs_state_t STATE_RST = IDLE;
    localparam logic       BIT_RST   = 1'b0;

endpackage

// File: rtl/multi_reg_sequencer_lowest_set16.sv
// Priority encoder: reports whether any bit is set and the index of the lowest one.
// The loop runs high to low so the last match, the lowest index, wins.
module lowest_set16
    import mrs_pkg::*;
#(
    parameter  int NREG  = MRS_NREG,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic [NREG-1:0]  vec_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o
);

    // Scan all bits; a lower set bit overrides any higher one found earlier.
    always_comb begin
        valid_o = 1'b0;
        index_o = {IDX_W{1'b0}};
        for (int i = NREG - 1; i >= 0; i--) begin
            valid_o = valid_o | vec_i[i];
            index_o = vec_i[i] ? IDX_W'(i) : index_o;
        end
    end

endmodule

// File: rtl/multi_reg_sequencer.sv
// LDM/STM block-transfer sequencer that drives the register bank ports and the data memory port.
// Every output comes straight from a flop loaded from the next-state values.
module multi_reg_sequencer
    import mrs_pkg::*;
#(
    parameter  int NREG   = MRS_NREG,
    parameter  int DATA_W = MRS_DATA_W,
    parameter  int ADDR_W = MRS_ADDR_W,
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic [NREG-1:0]   reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [IDX_W-1:0]  A1,
    input  logic [DATA_W-1:0] RD1,
    output logic [IDX_W-1:0]  A3,
    output logic              WE3,
    output logic [DATA_W-1:0] WD3,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] final_addr
);

    localparam logic [NREG-1:0]   ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(WORD_BYTES);

    mrs_state_t        state_q, state_d;
    logic [NREG-1:0]   mask_q,  mask_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              load_q,  load_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [IDX_W-1:0]  a1_q,    a1_d;
    logic [IDX_W-1:0]  a3_q,    a3_d;
    logic              we3_q,   we3_d;
    logic [DATA_W-1:0] wd3_q,   wd3_d;
    logic              req_q,   req_d;
    logic              mwe_q,   mwe_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic              enc_valid_s;
    logic [IDX_W-1:0]  enc_idx_s;

    lowest_set16 #(.NREG(NREG)) u_lowest (
        .vec_i   (mask_q),
        .valid_o (enc_valid_s),
        .index_o (enc_idx_s)
    );

    // Next-state logic; output flops are loaded from the state being entered.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        load_d  = load_q;
        addr_d  = addr_q;
        a1_d    = a1_q;
        a3_d    = a3_q;
        wd3_d   = wd3_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEL;
                    mask_d  = reg_list;
                    load_d  = is_load;
                    addr_d  = base_addr;
                end else begin
                    state_d = IDLE;
                end
            end
            SEL: begin
                if (!enc_valid_s) begin
                    state_d = DONE;
                end else begin
                    idx_d  = enc_idx_s;
                    mask_d = mask_q & ~(ONE_HOT0 << enc_idx_s);
                    if (load_q) begin
                        state_d = MEMRD;
                    end else begin
                        state_d = RDREG;
                        a1_d    = enc_idx_s;
                    end
                end
            end
            RDREG: begin
                state_d = STWAIT;
            end
            STWAIT: begin
                wdata_d = RD1;
                state_d = MEMWR;
            end
            MEMWR: begin
                if (mem_ack) begin
                    addr_d  = addr_q + STEP;
                    state_d = SEL;
                end else begin
                    state_d = MEMWR;
                end
            end
            MEMRD: begin
                if (mem_ack) begin
                    wd3_d   = mem_rdata;
                    a3_d    = idx_q;
                    state_d = REGWR;
                end else begin
                    state_d = MEMRD;
                end
            end
            REGWR: begin
                addr_d  = addr_q + STEP;
                state_d = SEL;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are pure functions of the next state so they can never leak outside it.
        req_d  = (state_d == MEMWR) || (state_d == MEMRD);
        mwe_d  = (state_d == MEMWR);
        we3_d  = (state_d == REGWR);
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STATE_RST;
            mask_q  <= {NREG{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            load_q  <= BIT_RST;
            addr_q  <= {ADDR_W{1'b0}};
            a1_q    <= {IDX_W{1'b0}};
            a3_q    <= {IDX_W{1'b0}};
            we3_q   <= BIT_RST;
            wd3_q   <= {DATA_W{1'b0}};
            req_q   <= BIT_RST;
            mwe_q   <= BIT_RST;
            wdata_q <= {DATA_W{1'b0}};
            busy_q  <= BIT_RST;
            done_q  <= BIT_RST;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            a1_q    <= a1_d;
            a3_q    <= a3_d;
            we3_q   <= we3_d;
            wd3_q   <= wd3_d;
            req_q   <= req_d;
            mwe_q   <= mwe_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The running address stops at base + 4n, which is exactly the final address.
    assign A1         = a1_q;
    assign A3         = a3_q;
    assign WE3        = we3_q;
    assign WD3        = wd3_q;
    assign mem_req    = req_q;
    assign mem_we     = mwe_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign final_addr = addr_q;

endmodule

// File: tb/tb_multi_reg_sequencer.sv
// Randomized bench for multi_reg_sequencer: models the register bank and memory,
// predicts transfers from the register list and base address, and checks latency and protocol.
module tb_multi_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic [15:0] reg_list = 16'h0;
    logic [31:0] base_addr = 32'h0;
    logic [3:0]  A1, A3;
    logic [31:0] RD1 = 32'h0;
    logic [31:0] WD3, mem_addr, mem_wdata, final_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        WE3, mem_req, mem_we, busy, done;
    logic        mem_ack = 1'b0;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int cur_delay = 0;
    int viol = 0;
    int done_cnt = 0;

    logic [31:0] bank [16];
    logic [31:0] ref_bank [16];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [63:0] obs_st [$];
    logic [63:0] obs_rw [$];

    multi_reg_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_load    (is_load),
        .reg_list   (reg_list),
        .base_addr  (base_addr),
        .A1         (A1),
        .RD1        (RD1),
        .A3         (A3),
        .WE3        (WE3),
        .WD3        (WD3),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .final_addr (final_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank read port: data appears one edge after the address.
    always @(posedge clk) RD1 <= bank[A1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory responder and bus monitor, evaluated mid-cycle.
    initial begin : mon
        logic        req_prev;
        logic        we_prev;
        logic [31:0] addr_prev;
        logic [31:0] wd_prev;
        int          wait_cnt;
        req_prev = 1'b0; we_prev = 1'b0; addr_prev = 32'h0; wd_prev = 32'h0; wait_cnt = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst) begin
                req_prev = 1'b0;
                wait_cnt = 0;
            end else begin
                if (done) done_cnt++;
                if (busy && done) viol++;
                if (!busy && (WE3 || mem_req)) viol++;
                if (WE3) begin
                    obs_rw.push_back({28'h0, A3, WD3});
                    bank[A3] = WD3;
                end
                if (mem_req) begin
                    if (req_prev && (mem_addr !== addr_prev || mem_we !== we_prev ||
                                     (mem_we && mem_wdata !== wd_prev))) viol++;
                    addr_prev = mem_addr; we_prev = mem_we; wd_prev = mem_wdata;
                    if (wait_cnt >= cur_delay) begin
                        mem_ack  = 1'b1;
                        wait_cnt = 0;
                        req_prev = 1'b0;
                        if (mem_we) begin
                            mem[mem_addr] = mem_wdata;
                            obs_st.push_back({mem_addr, mem_wdata});
                        end else begin
                            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;
                        end
                    end else begin
                        wait_cnt++;
                        req_prev = 1'b1;
                    end
                end else begin
                    req_prev = 1'b0;
                    wait_cnt = 0;
                    if ($urandom_range(0, 5) == 0) begin
                        mem_ack   = 1'b1;
                        mem_rdata = $urandom;
                    end
                end
            end
        end
    end

    task automatic reseed_bank();
        for (int i = 0; i < 16; i++) begin
            bank[i]     = $urandom;
            ref_bank[i] = bank[i];
        end
    endtask

    task automatic set_mem(input logic [31:0] a, input logic [31:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // One LDM/STM transaction checked against the list-walk model.
    task automatic run_xfer(input bit ld, input logic [15:0] list, input logic [31:0] base,
                            input int d, input bit poke);
        logic [63:0] exp_st [$];
        logic [63:0] exp_rw [$];
        logic [31:0] a;
        logic [31:0] fin;
        int n, lat, t, s_cyc;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                a = base + 32'(4 * n);
                if (ld) begin
                    if (!ref_mem.exists(a)) set_mem(a, $urandom);
                    exp_rw.push_back({32'(i), ref_mem[a]});
                    ref_bank[i] = ref_mem[a];
                end else begin
                    exp_st.push_back({a, ref_bank[i]});
                    ref_mem[a] = ref_bank[i];
                end
                n++;
            end
        end
        fin = base + 32'(4 * n);
        lat = n * ((ld ? 3 : 4) + d) + 2;

        obs_st.delete(); obs_rw.delete();
        viol = 0; done_cnt = 0; cur_delay = d;
        @(negedge clk);
        start = 1'b1; is_load = ld; reg_list = list; base_addr = base; s_cyc = cyc;
        @(negedge clk);
        start = 1'b0; is_load = 1'($urandom); reg_list = 16'($urandom); base_addr = $urandom;
        t = 1;
        while (!done && t < 1000) begin
            @(negedge clk);
            t++;
            start = (poke && t == 3);
        end
        start = 1'b0;
        check_eq("done_seen", done, 1'b1);
        check_eq("latency", cyc - s_cyc, lat);
        check_eq("final_addr", final_addr, fin);
        check_eq("busy_at_done", busy, 1'b0);
        @(negedge clk);
        check_eq("done_width", done, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("final_hold", final_addr, fin);
        check_eq("done_count", done_cnt, 1);
        check_eq("protocol", viol, 0);
        check_eq("n_mem_wr", obs_st.size(), exp_st.size());
        for (int k = 0; k < exp_st.size() && k < obs_st.size(); k++)
            check_eq("mem_wr", obs_st[k], exp_st[k]);
        check_eq("n_reg_wr", obs_rw.size(), exp_rw.size());
        for (int k = 0; k < exp_rw.size() && k < obs_rw.size(); k++)
            check_eq("reg_wr", obs_rw[k], exp_rw[k]);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int nwr;
        logic [15:0] lst;
        reseed_bank();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_we3", WE3, 1'b0);
        check_eq("rst_req", mem_req, 1'b0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_final", final_addr, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        bank[0] = 32'hA; ref_bank[0] = 32'hA;
        bank[2] = 32'hB; ref_bank[2] = 32'hB;
        run_xfer(1'b0, 16'h0005, 32'h100, 0, 1'b0);
        check_eq("stm_mem0", ref_mem[32'h100], 32'hA);

        set_mem(32'h200, 32'h11);
        set_mem(32'h204, 32'h22);
        run_xfer(1'b1, 16'h8001, 32'h200, 0, 1'b0);
        run_xfer(1'b0, 16'h0000, 32'h40, 0, 1'b0);
        run_xfer(1'b1, 16'h0000, 32'h80, 2, 1'b0);
        run_xfer(1'b0, 16'h8421, 32'h400, 3, 1'b0);
        run_xfer(1'b1, 16'h1248, 32'h500, 3, 1'b0);
        run_xfer(1'b0, 16'h00F0, 32'h600, 1, 1'b1);
        run_xfer(1'b1, 16'hC003, 32'h700, 0, 1'b1);
        run_xfer(1'b0, 16'h000F, 32'hFFFF_FFF8, 0, 1'b0);
        run_xfer(1'b1, 16'hFFFF, 32'hFFFF_FFF0, 1, 1'b0);

        cur_delay = 1;
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; reg_list = 16'h0F00; base_addr = 32'h300;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_we3", WE3, 1'b0);
        check_eq("arst_req", mem_req, 1'b0);
        check_eq("arst_wd3", WD3, 32'h0);
        check_eq("arst_a3", A3, 4'h0);
        check_eq("arst_addr", mem_addr, 32'h0);
        done_cnt = 0;
        nwr = obs_rw.size();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("arst_no_done", done_cnt, 0);
        check_eq("arst_no_wr", obs_rw.size(), nwr);
        reseed_bank();
        run_xfer(1'b1, 16'h0F00, 32'h300, 0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            lst = 16'($urandom);
            if ($urandom_range(0, 2) == 0) lst = lst & 16'($urandom);
            run_xfer(1'($urandom_range(0, 1)), lst, $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 3), ($countones(lst) >= 2) && ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
